fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
Program-counter and fetch-control stage directly upstream of the instruction ROM in the RV32I single-cycle core. Holds the PC register and drives the ROM byte address. Takes the ROM's asynchronous instruction word back in and hands it to decode with a valid flag. Selects the next PC and handles run, halt and error states, including halt on ECALL, misaligned-redirect trapping and a retired-instruction counter.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
WDT_LIMIT, 1024, cycles in RUN without retirement before watchdog halt; used only with the optional feature

Ports:
CLK  input  1  core clock; all state updates on the rising edge
RST_N  input  1  asynchronous active-low reset
STALL  input  1  hold the current PC; no retire this cycle
REDIRECT  input  1  branch/jump taken by the current instruction
REDIRECT_PC  input  32  branch/jump target byte address
RESUME  input  1  single-cycle pulse; leave HALT
INSTR_IN  input  32  instruction word from the ROM, combinational on ADDR
ADDR  output  32  byte address to the ROM; equals the PC register
PC_OUT  output  32  PC of INSTR_OUT, to decode and the branch adder
INSTR_OUT  output  32  INSTR_IN when VALID=1, otherwise 32'h00000013 (NOP)
VALID  output  1  current instruction retires this cycle
HALTED  output  1  state is HALT
MISALIGN_ERR  output  1  state is ERROR
ERR_PC  output  32  captured misaligned target
RETIRE_CNT  output  32  count of retired instructions

Behaviour:
- States: RUN, HALT, ERROR. Encoding is free.
- Reset (RST_N=0, asynchronous): state=RUN, PC=RESET_PC, ERR_PC=0, RETIRE_CNT=0. Outputs while reset is held: ADDR=PC_OUT=RESET_PC, HALTED=0, MISALIGN_ERR=0. Reset asserted mid-operation overrides everything immediately.
- ADDR, PC_OUT, VALID, INSTR_OUT, HALTED and MISALIGN_ERR are combinational from the registers and inputs. There is zero-cycle fetch latency: an instruction issues in the same cycle its PC is presented.
- VALID = (state==RUN) && !STALL.
- RUN, next-state priority on each edge:
  1. STALL=1: PC holds; RETIRE_CNT holds; REDIRECT is ignored.
  2. INSTR_IN==32'h00000073 (ECALL): the instruction retires (RETIRE_CNT+1); PC holds at the ECALL address; state goes to HALT. A simultaneous REDIRECT is ignored.
  3. REDIRECT=1 and REDIRECT_PC[1:0]!=0: no retire; PC holds; ERR_PC<=REDIRECT_PC; state goes to ERROR.
  4. REDIRECT=1 with an aligned target: PC<=REDIRECT_PC; RETIRE_CNT+1.
  5. Otherwise: PC<=PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0); RETIRE_CNT+1.
- HALT: VALID=0; PC and RETIRE_CNT hold.
  - RESUME=1: PC<=PC+4; state goes to RUN.
  - STALL and REDIRECT are ignored.
- ERROR: VALID=0; everything holds; RESUME is ignored. The only exit is reset.
- RESUME in RUN has no effect.
- RETIRE_CNT wraps from 0xFFFFFFFF to 0.
- ROM range is not checked. Addresses beyond the ROM alias inside the ROM.

Optional Feature:
- Macro: FETCH_WATCHDOG_EN.
- Defined:
  - A counter of RUN cycles with VALID=0 is added. It clears on any retire and on reset.
  - When the counter reaches WDT_LIMIT, the state goes to HALT on that edge and the PC holds.
  - Extra output port WDT_TRIP (1 bit) is added. It is sticky, set on the trip, and cleared by RESUME or reset.
  - RESUME after a watchdog trip returns to RUN with PC unchanged, not PC+4.
- Undefined: no counter and no WDT_TRIP port. Behaviour is exactly as in Behaviour above.

Test Plan:
1. Reset release with no stalls and a NOP-filled ROM -> ADDR steps 0x00, 0x04, 0x08, 0x0C on consecutive edges; RETIRE_CNT=3 after 3 edges.
2. STALL=1 for 2 cycles at PC=0x08 -> ADDR stays 0x08, VALID=0, RETIRE_CNT frozen; the edge after STALL drops gives ADDR=0x0C.
3. At PC=0x1C, REDIRECT=1 with REDIRECT_PC=0x14 -> next ADDR=0x14, RETIRE_CNT+1. With REDIRECT_PC=0x16 instead -> MISALIGN_ERR=1, ERR_PC=0x16, ADDR held at 0x1C, RESUME ignored.
4. INSTR_IN=32'h00000073 at PC=0x24 with REDIRECT=1 the same cycle -> VALID=1 that cycle, then HALTED=1 with ADDR=0x24; RESUME pulse -> RUN with ADDR=0x28.
5. RST_N pulled low mid-cycle while in ERROR -> outputs return to RESET_PC / RUN / RETIRE_CNT=0 immediately, before any clock edge.
6. With FETCH_WATCHDOG_EN defined and WDT_LIMIT=4, STALL held high -> on the 4th stalled edge HALTED=1 and WDT_TRIP=1; RESUME -> RUN at the same PC with WDT_TRIP=0.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// PC register and fetch control for the RV32I single-cycle core: RUN/HALT/ERROR sequencing,
// ECALL halt, misaligned-redirect trap and retire counter. Optional watchdog: FETCH_WATCHDOG_EN.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned WDT_LIMIT = 1024
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        STALL,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   input  logic        RESUME,
   input  logic [31:0] INSTR_IN,
   output logic [31:0] ADDR,
   output logic [31:0] PC_OUT,
   output logic [31:0] INSTR_OUT,
   output logic        VALID,
   output logic        HALTED,
   output logic        MISALIGN_ERR,
   output logic [31:0] ERR_PC,
`ifdef FETCH_WATCHDOG_EN
   output logic        WDT_TRIP,
`endif
   output logic [31:0] RETIRE_CNT
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] err_pc, err_pc_nxt;
   logic [31:0] retire_cnt, retire_cnt_nxt;
   logic        issue;
   logic        is_ecall;
   logic        target_misaligned;
   logic        wdt_expire;
   logic        resume_step;

   // Handshake: VALID qualifies INSTR_OUT/PC_OUT for the current cycle only; there is no ready.
   // STALL is the downstream back-pressure: it forces VALID low and freezes the PC.
   assign issue             = (state == ST_RUN) && !STALL;
   assign is_ecall          = (INSTR_IN == ECALL_WORD);
   assign target_misaligned = (REDIRECT_PC[1:0] != 2'b00);

`ifdef FETCH_WATCHDOG_EN
   localparam int unsigned    WDT_W       = $clog2(WDT_LIMIT + 1);
   localparam logic [WDT_W:0] WDT_LIMIT_V = (WDT_W + 1)'(WDT_LIMIT);

   logic [WDT_W-1:0] wdt_cnt, wdt_cnt_nxt;
   logic             wdt_trip, wdt_trip_nxt;

   assign wdt_expire = (state == ST_RUN) && STALL &&
                       (({1'b0, wdt_cnt} + 1'b1) >= WDT_LIMIT_V);
   // A watchdog halt retired nothing, so RESUME refetches the same PC.
   assign resume_step = !wdt_trip;

   always_comb begin
      wdt_cnt_nxt  = '0;
      wdt_trip_nxt = wdt_trip;
      if ((state == ST_RUN) && STALL && !wdt_expire) begin
         wdt_cnt_nxt = wdt_cnt + 1'b1;
      end
      if (wdt_expire) begin
         wdt_trip_nxt = 1'b1;
      end else if ((state == ST_HALT) && RESUME) begin
         wdt_trip_nxt = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wdt_cnt  <= '0;
         wdt_trip <= 1'b0;
      end else begin
         wdt_cnt  <= wdt_cnt_nxt;
         wdt_trip <= wdt_trip_nxt;
      end
   end

   assign WDT_TRIP = wdt_trip;
`else
   logic unused_wdt;

   assign wdt_expire  = 1'b0;
   assign resume_step = 1'b1;
   assign unused_wdt  = (WDT_LIMIT != 0);
`endif

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      err_pc_nxt     = err_pc;
      retire_cnt_nxt = retire_cnt;
      case (state)
         ST_RUN: begin
            if (STALL) begin
               if (wdt_expire) begin
                  state_nxt = ST_HALT;
               end
            end else if (is_ecall) begin
               // ECALL retires but parks the PC on itself.
               retire_cnt_nxt = retire_cnt + 32'd1;
               state_nxt      = ST_HALT;
            end else if (REDIRECT && target_misaligned) begin
               err_pc_nxt = REDIRECT_PC;
               state_nxt  = ST_ERROR;
            end else if (REDIRECT) begin
               pc_nxt         = REDIRECT_PC;
               retire_cnt_nxt = retire_cnt + 32'd1;
            end else begin
               pc_nxt         = pc + 32'd4;
               retire_cnt_nxt = retire_cnt + 32'd1;
            end
         end
         ST_HALT: begin
            if (RESUME) begin
               state_nxt = ST_RUN;
               if (resume_step) begin
                  pc_nxt = pc + 32'd4;
               end
            end
         end
         ST_ERROR: begin
            // Terminal until reset.
         end
         default: begin
            state_nxt = ST_ERROR;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_RUN;
         pc         <= RESET_PC;
         err_pc     <= 32'h0000_0000;
         retire_cnt <= 32'h0000_0000;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         err_pc     <= err_pc_nxt;
         retire_cnt <= retire_cnt_nxt;
      end
   end

   assign ADDR         = pc;
   assign PC_OUT       = pc;
   assign VALID        = issue;
   assign INSTR_OUT    = issue ? INSTR_IN : NOP_WORD;
   assign HALTED       = (state == ST_HALT);
   assign MISALIGN_ERR = (state == ST_ERROR);
   assign ERR_PC       = err_pc;
   assign RETIRE_CNT   = retire_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus randomized traffic against a rule-level model.
// Build with FETCH_WATCHDOG_EN defined to also exercise the watchdog (WDT_LIMIT=4).
module tb_fetch_pc_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam int unsigned WDT   = 4;
   localparam int M_RUN = 0, M_HALT = 1, M_ERR = 2;

   logic        CLK = 1'b0;
   logic        RST_N, STALL, REDIRECT, RESUME;
   logic [31:0] REDIRECT_PC, INSTR_IN;
   logic [31:0] ADDR, PC_OUT, INSTR_OUT, ERR_PC, RETIRE_CNT;
   logic        VALID, HALTED, MISALIGN_ERR;
`ifdef FETCH_WATCHDOG_EN
   logic        WDT_TRIP;
`endif

   int vectors = 0;
   int miscompares = 0;

   int          m_state;
   logic [31:0] m_pc, m_err, m_cnt;
   int          m_idle;
   logic        m_trip;

   fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .WDT_LIMIT(WDT)) dut (
      .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REDIRECT(REDIRECT),
      .REDIRECT_PC(REDIRECT_PC), .RESUME(RESUME), .INSTR_IN(INSTR_IN),
      .ADDR(ADDR), .PC_OUT(PC_OUT), .INSTR_OUT(INSTR_OUT), .VALID(VALID),
      .HALTED(HALTED), .MISALIGN_ERR(MISALIGN_ERR), .ERR_PC(ERR_PC),
`ifdef FETCH_WATCHDOG_EN
      .WDT_TRIP(WDT_TRIP),
`endif
      .RETIRE_CNT(RETIRE_CNT)
   );

   always #5 CLK = ~CLK;

   // ---------------- clock/reset and driver tasks ----------------
   task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                        input logic res, input logic [31:0] instr);
      STALL = s; REDIRECT = r; REDIRECT_PC = rpc; RESUME = res; INSTR_IN = instr;
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset;
      RST_N = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP);
      @(negedge CLK);
      RST_N = 1'b1;
      m_state = M_RUN; m_pc = 32'h0; m_err = 32'h0; m_cnt = 32'h0; m_idle = 0; m_trip = 1'b0;
   endtask

   // Reference model: one clock edge of the fetch stage, stated directly from its rules.
   task automatic model_step(input logic s, input logic r, input logic [31:0] rpc,
                             input logic res, input logic [31:0] instr);
      if (m_state == M_RUN) begin
         if (s) begin
`ifdef FETCH_WATCHDOG_EN
            m_idle = m_idle + 1;
            if (m_idle >= int'(WDT)) begin
               m_state = M_HALT; m_trip = 1'b1; m_idle = 0;
            end
`endif
         end else begin
            m_idle = 0;
            if (instr == ECALL) begin
               m_cnt = m_cnt + 1; m_state = M_HALT;
            end else if (r && (rpc % 4 != 0)) begin
               m_err = rpc; m_state = M_ERR;
            end else begin
               m_cnt = m_cnt + 1;
               m_pc  = r ? rpc : m_pc + 4;
            end
         end
      end else if (m_state == M_HALT) begin
         if (res) begin
            m_state = M_RUN;
            if (!m_trip) m_pc = m_pc + 4;
            m_trip = 1'b0;
            m_idle = 0;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      RST_N = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP);
      #3;
      vectors++; if (ADDR !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h exp %h", ADDR, 32'h0); end
      vectors++; if (PC_OUT !== 32'h0) begin miscompares++; $display("FAIL reset_pc_out: got %h exp %h", PC_OUT, 32'h0); end
      vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b exp 0", HALTED); end
      vectors++; if (MISALIGN_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", MISALIGN_ERR); end
      vectors++; if (RETIRE_CNT !== 32'h0) begin miscompares++; $display("FAIL reset_cnt: got %h exp 0", RETIRE_CNT); end
      vectors++; if (ERR_PC !== 32'h0) begin miscompares++; $display("FAIL reset_err_pc: got %h exp 0", ERR_PC); end
      do_reset;
   endtask

   task automatic test_sequential;
      logic [31:0] exp_addr;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         exp_addr = 32'(i * 4);
         #1;
         vectors++; if (ADDR !== exp_addr) begin miscompares++; $display("FAIL seq_addr step %0d: got %h exp %h", i, ADDR, exp_addr); end
         vectors++; if (VALID !== 1'b1) begin miscompares++; $display("FAIL seq_valid step %0d: got %b exp 1", i, VALID); end
         if (i < 3) tick;
      end
      vectors++; if (RETIRE_CNT !== 32'd3) begin miscompares++; $display("FAIL seq_cnt: got %0d exp 3", RETIRE_CNT); end
   endtask

   task automatic test_stall;
      do_reset;
      tick; tick;
      drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0050_0093);
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++; if (VALID !== 1'b0) begin miscompares++; $display("FAIL stall_valid %0d: got %b exp 0", i, VALID); end
         vectors++; if (INSTR_OUT !== NOP) begin miscompares++; $display("FAIL stall_nop %0d: got %h exp %h", i, INSTR_OUT, NOP); end
         tick;
         vectors++; if (ADDR !== 32'h8) begin miscompares++; $display("FAIL stall_addr %0d: got %h exp 8", i, ADDR); end
         vectors++; if (RETIRE_CNT !== 32'd2) begin miscompares++; $display("FAIL stall_cnt %0d: got %0d exp 2", i, RETIRE_CNT); end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0050_0093);
      #1;
      vectors++; if (INSTR_OUT !== 32'h0050_0093) begin miscompares++; $display("FAIL stall_pass: got %h exp 00500093", INSTR_OUT); end
      tick;
      vectors++; if (ADDR !== 32'hC) begin miscompares++; $display("FAIL stall_release: got %h exp c", ADDR); end
      vectors++; if (RETIRE_CNT !== 32'd3) begin miscompares++; $display("FAIL stall_release_cnt: got %0d exp 3", RETIRE_CNT); end
   endtask

   task automatic test_redirect;
      do_reset;
      drive(1'b0, 1'b1, 32'h1C, 1'b0, NOP); tick;
      drive(1'b0, 1'b1, 32'h14, 1'b0, NOP); tick;
      vectors++; if (ADDR !== 32'h14) begin miscompares++; $display("FAIL redir_addr: got %h exp 14", ADDR); end
      vectors++; if (RETIRE_CNT !== 32'd2) begin miscompares++; $display("FAIL redir_cnt: got %0d exp 2", RETIRE_CNT); end
      drive(1'b0, 1'b1, 32'h1C, 1'b0, NOP); tick;
      drive(1'b0, 1'b1, 32'h16, 1'b0, NOP); tick;
      vectors++; if (MISALIGN_ERR !== 1'b1) begin miscompares++; $display("FAIL mis_err: got %b exp 1", MISALIGN_ERR); end
      vectors++; if (ERR_PC !== 32'h16) begin miscompares++; $display("FAIL mis_err_pc: got %h exp 16", ERR_PC); end
      vectors++; if (ADDR !== 32'h1C) begin miscompares++; $display("FAIL mis_addr: got %h exp 1c", ADDR); end
      vectors++; if (RETIRE_CNT !== 32'd3) begin miscompares++; $display("FAIL mis_cnt: got %0d exp 3", RETIRE_CNT); end
      drive(1'b0, 1'b0, 32'h0, 1'b1, NOP);
      #1;
      vectors++; if (VALID !== 1'b0) begin miscompares++; $display("FAIL mis_valid: got %b exp 0", VALID); end
      tick;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP); tick;
      vectors++; if (MISALIGN_ERR !== 1'b1) begin miscompares++; $display("FAIL mis_resume_err: got %b exp 1", MISALIGN_ERR); end
      vectors++; if (ADDR !== 32'h1C) begin miscompares++; $display("FAIL mis_resume_addr: got %h exp 1c", ADDR); end
   endtask

   task automatic test_wrap;
      do_reset;
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, NOP); tick;
      vectors++; if (ADDR !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top: got %h exp fffffffc", ADDR); end
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP); tick;
      vectors++; if (ADDR !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got %h exp 0", ADDR); end
   endtask

   task automatic test_ecall;
      do_reset;
      drive(1'b0, 1'b1, 32'h24, 1'b0, NOP); tick;
      drive(1'b0, 1'b1, 32'h40, 1'b0, ECALL);
      #1;
      vectors++; if (VALID !== 1'b1) begin miscompares++; $display("FAIL ecall_valid: got %b exp 1", VALID); end
      vectors++; if (INSTR_OUT !== ECALL) begin miscompares++; $display("FAIL ecall_instr: got %h exp %h", INSTR_OUT, ECALL); end
      tick;
      vectors++; if (HALTED !== 1'b1) begin miscompares++; $display("FAIL ecall_halted: got %b exp 1", HALTED); end
      vectors++; if (ADDR !== 32'h24) begin miscompares++; $display("FAIL ecall_addr: got %h exp 24", ADDR); end
      vectors++; if (RETIRE_CNT !== 32'd2) begin miscompares++; $display("FAIL ecall_cnt: got %0d exp 2", RETIRE_CNT); end
      drive(1'b0, 1'b1, 32'h80, 1'b0, NOP);
      #1;
      vectors++; if (VALID !== 1'b0) begin miscompares++; $display("FAIL halt_valid: got %b exp 0", VALID); end
      tick;
      vectors++; if (ADDR !== 32'h24) begin miscompares++; $display("FAIL halt_hold: got %h exp 24", ADDR); end
      drive(1'b0, 1'b0, 32'h0, 1'b1, NOP); tick;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP);
      vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL resume_halted: got %b exp 0", HALTED); end
      vectors++; if (ADDR !== 32'h28) begin miscompares++; $display("FAIL resume_addr: got %h exp 28", ADDR); end
      drive(1'b0, 1'b0, 32'h0, 1'b1, NOP); tick;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP);
      vectors++; if (ADDR !== 32'h2C) begin miscompares++; $display("FAIL run_resume_addr: got %h exp 2c", ADDR); end
   endtask

   task automatic test_async_reset;
      do_reset;
      tick;
      drive(1'b0, 1'b1, 32'h2, 1'b0, NOP); tick;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP);
      vectors++; if (MISALIGN_ERR !== 1'b1) begin miscompares++; $display("FAIL areset_pre_err: got %b exp 1", MISALIGN_ERR); end
      #2;
      RST_N = 1'b0;
      #1;
      vectors++; if (ADDR !== 32'h0) begin miscompares++; $display("FAIL areset_addr: got %h exp 0", ADDR); end
      vectors++; if (MISALIGN_ERR !== 1'b0) begin miscompares++; $display("FAIL areset_err: got %b exp 0", MISALIGN_ERR); end
      vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL areset_halted: got %b exp 0", HALTED); end
      vectors++; if (RETIRE_CNT !== 32'h0) begin miscompares++; $display("FAIL areset_cnt: got %0d exp 0", RETIRE_CNT); end
      vectors++; if (ERR_PC !== 32'h0) begin miscompares++; $display("FAIL areset_err_pc: got %h exp 0", ERR_PC); end
      do_reset;
   endtask

`ifdef FETCH_WATCHDOG_EN
   task automatic test_watchdog;
      do_reset;
      drive(1'b1, 1'b0, 32'h0, 1'b0, NOP);
      for (int i = 1; i <= 4; i++) begin
         tick;
         vectors++; if (HALTED !== (i == 4)) begin miscompares++; $display("FAIL wdt_halted edge %0d: got %b exp %b", i, HALTED, (i == 4)); end
         vectors++; if (WDT_TRIP !== (i == 4)) begin miscompares++; $display("FAIL wdt_trip edge %0d: got %b exp %b", i, WDT_TRIP, (i == 4)); end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, NOP); tick;
      drive(1'b0, 1'b0, 32'h0, 1'b0, NOP);
      vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL wdt_resume_halted: got %b exp 0", HALTED); end
      vectors++; if (WDT_TRIP !== 1'b0) begin miscompares++; $display("FAIL wdt_resume_trip: got %b exp 0", WDT_TRIP); end
      vectors++; if (ADDR !== 32'h0) begin miscompares++; $display("FAIL wdt_resume_addr: got %h exp 0", ADDR); end
   endtask
`endif

   task automatic test_random;
      logic        s, r, res, e_valid;
      logic [31:0] rpc, instr, e_instr;
      do_reset;
      for (int i = 0; i < 1500; i++) begin
         if ((m_state == M_ERR) && ($urandom_range(0, 3) == 0)) do_reset;
         s   = ($urandom_range(0, 3) == 0);
         r   = ($urandom_range(0, 3) == 0);
         res = ($urandom_range(0, 2) == 0);
         rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 30) == 0) rpc = 32'hFFFF_FFFC;
         instr = ($urandom_range(0, 11) == 0) ? ECALL : 32'($urandom);
         drive(s, r, rpc, res, instr);
         #1;
         e_valid = (m_state == M_RUN) && !s;
         e_instr = e_valid ? instr : NOP;
         vectors++; if (ADDR !== m_pc) begin miscompares++; $display("FAIL rand_addr cyc %0d: got %h exp %h", i, ADDR, m_pc); end
         vectors++; if (PC_OUT !== m_pc) begin miscompares++; $display("FAIL rand_pc_out cyc %0d: got %h exp %h", i, PC_OUT, m_pc); end
         vectors++; if (VALID !== e_valid) begin miscompares++; $display("FAIL rand_valid cyc %0d: got %b exp %b", i, VALID, e_valid); end
         vectors++; if (INSTR_OUT !== e_instr) begin miscompares++; $display("FAIL rand_instr cyc %0d: got %h exp %h", i, INSTR_OUT, e_instr); end
         vectors++; if (HALTED !== (m_state == M_HALT)) begin miscompares++; $display("FAIL rand_halted cyc %0d: got %b exp %b", i, HALTED, (m_state == M_HALT)); end
         vectors++; if (MISALIGN_ERR !== (m_state == M_ERR)) begin miscompares++; $display("FAIL rand_err cyc %0d: got %b exp %b", i, MISALIGN_ERR, (m_state == M_ERR)); end
         vectors++; if (ERR_PC !== m_err) begin miscompares++; $display("FAIL rand_err_pc cyc %0d: got %h exp %h", i, ERR_PC, m_err); end
         vectors++; if (RETIRE_CNT !== m_cnt) begin miscompares++; $display("FAIL rand_cnt cyc %0d: got %0d exp %0d", i, RETIRE_CNT, m_cnt); end
`ifdef FETCH_WATCHDOG_EN
         vectors++; if (WDT_TRIP !== m_trip) begin miscompares++; $display("FAIL rand_wdt_trip cyc %0d: got %b exp %b", i, WDT_TRIP, m_trip); end
`endif
         model_step(s, r, rpc, res, instr);
         tick;
      end
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_stall;
      test_redirect;
      test_wrap;
      test_ecall;
      test_async_reset;
`ifdef FETCH_WATCHDOG_EN
      test_watchdog;
`endif
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
